// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-lite sequencing controller.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    BALRNV = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE  = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW     = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW     = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'b000100;
  localparam logic [OP_W-1:0] OP_J      = 6'b000010;
  localparam logic [OP_W-1:0] OP_BALRNV = 6'b101111;

  localparam logic [1:0] ALUB_RT    = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_outdec.sv
// Combinational control-output decoder: Moore outputs per state, with the
// FETCH handshake (mem_ready) and BALRNV overflow gating (v_flag) folded in.
module mc_outdec
  import mc_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               mem_ready,
  input  logic               v_flag,
  input  logic               rst_n,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               link,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource
);

  // Per-state output decode; write strobes are held off while in reset
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    link        = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = ALUB_RT;
    aluop       = ALUOP_ADD;
    pcsource    = PCS_ALU;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = ALUB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE: alusrcb = ALUB_IMMSH;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCS_ALUOUT;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = PCS_JUMP;
      end
      BALRNV: begin
        if (!v_flag) begin
          regwrite = 1'b1;
          link     = 1'b1;
          regdst   = 1'b1;
          pcwrite  = 1'b1;
          pcsource = PCS_RS;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      irwrite     = 1'b0;
      regwrite    = 1'b0;
      memwrite    = 1'b0;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS-lite sequencer: state machine, retired-instruction counter
// and sticky illegal-opcode flag; control outputs come from mc_outdec.
module mc_control
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zout,
  input  logic               v_flag,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               link,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic [STATE_W-1:0] state,
  output logic               err,
  output logic [CNT_W-1:0]   instret
);

  state_t             state_q;
  state_t             next_state;
  logic               retire;
  logic               illegal;
  logic               err_q;
  logic [CNT_W-1:0]   instret_q;

  // zout is consumed by the datapath's conditional PC load, not by sequencing
  logic unused_zout;
  assign unused_zout = zout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= next_state;
  end

  // Next-state logic, plus retire/illegal strobes for the exit edge
  always_comb begin
    next_state = FETCH;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH:  next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_BALRNV:    next_state = BALRNV;
          default: begin
            next_state = FETCH;
            illegal    = 1'b1;
            retire     = 1'b1;
          end
        endcase
      end
      MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB:  begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      MEMWR:  begin
        next_state = mem_ready ? FETCH : MEMWR;
        retire     = mem_ready;
      end
      EXEC:   next_state = RWB;
      RWB, BRANCH, JUMP, BALRNV: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Retired-instruction counter (wraps) and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (retire)  instret_q <= instret_q + CNT_W'(1);
      if (illegal) err_q     <= 1'b1;
    end
  end

  // Control output decode
  mc_outdec u_outdec (
    .state       (state_q),
    .mem_ready   (mem_ready),
    .v_flag      (v_flag),
    .rst_n       (rst_n),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .link        (link),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsource    (pcsource)
  );

  assign state   = state_q;
  assign err     = err_q;
  assign instret = instret_q;

endmodule
